reorder_buffer: RTL

REORDER_BUFFER -- requirements
Module: reorder_buffer

---
 rtl/reorder_buffer.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/reorder_buffer.sv
`default_nettype none
// ============================================================================
//  Module   : reorder_buffer
//  Purpose  : Circular reorder buffer that retires results strictly in
//             allocation order. Dispatch allocates at the tail, execution
//             units complete entries by tag, and the head entry commits
//             once it is done and the register file accepts it.
//  Ports    : clk, rst_n            - clock, async active-low reset
//             flush                 - discard every entry
//             alloc_*               - allocation request / tag handshake
//             wb_*                  - writeback of a result by tag
//             commit_*              - head entry retirement handshake
//             count, empty, full    - occupancy status
//  Revision : 1.0  initial release
// ============================================================================
module reorder_buffer #(
   parameter int DEPTH  = 8,
   parameter int TAG_W  = 3,
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              flush,
   input  logic              alloc_valid,
   input  logic              alloc_uses_rw,
   input  logic [4:0]        alloc_rw_addr,
   output logic              alloc_ready,
   output logic [TAG_W-1:0]  alloc_tag,
   input  logic              wb_valid,
   input  logic [TAG_W-1:0]  wb_tag,
   input  logic [DATA_W-1:0] wb_data,
   output logic              commit_valid,
   input  logic              commit_ready,
   output logic [TAG_W-1:0]  commit_tag,
   output logic              commit_uses_rw,
   output logic [4:0]        commit_rw_addr,
   output logic [DATA_W-1:0] commit_data,
   output logic [TAG_W:0]    count,
   output logic              empty,
   output logic              full
);

   localparam logic [TAG_W:0] c_full_count = (TAG_W+1)'(DEPTH);

   // Control state (reset) and payload state (no reset needed: payload is
   // only ever observed through a valid entry).
   logic [DEPTH-1:0]  valid_q, valid_d;
   logic [DEPTH-1:0]  done_q, done_d;
   logic [DEPTH-1:0]  uses_rw_q, uses_rw_d;
   logic [4:0]        rw_addr_q [DEPTH];
   logic [4:0]        rw_addr_d [DEPTH];
   logic [DATA_W-1:0] data_q [DEPTH];
   logic [DATA_W-1:0] data_d [DEPTH];
   logic [TAG_W-1:0]  head_q, head_d;
   logic [TAG_W-1:0]  tail_q, tail_d;
   logic [TAG_W:0]    count_q, count_d;

   logic w_alloc_fire;
   logic w_commit_fire;

   assign empty = (count_q == '0);
   assign full  = (count_q == c_full_count);
   assign count = count_q;

   // Ready is a function of registered occupancy only; a commit in the same
   // cycle never frees a slot early. rst_n gating keeps it low while the
   // reset is held.
   assign alloc_ready = rst_n && !full && !flush;
   assign alloc_tag   = tail_q;

   assign commit_valid   = valid_q[head_q] && done_q[head_q] && !flush;
   assign commit_tag     = head_q;
   assign commit_uses_rw = uses_rw_q[head_q];
   assign commit_rw_addr = rw_addr_q[head_q];
   assign commit_data    = data_q[head_q];

   assign w_alloc_fire  = alloc_valid && alloc_ready;
   assign w_commit_fire = commit_valid && commit_ready;

   always_comb begin
      valid_d   = valid_q;
      done_d    = done_q;
      uses_rw_d = uses_rw_q;
      rw_addr_d = rw_addr_q;
      data_d    = data_q;
      head_d    = head_q;
      tail_d    = tail_q;
      count_d   = count_q;

      if (flush) begin
         valid_d = '0;
         done_d  = '0;
         head_d  = '0;
         tail_d  = '0;
         count_d = '0;
      end else begin
         // A writeback aimed at the slot being allocated this cycle sees the
         // old (invalid) entry and is dropped; a repeated writeback simply
         // overwrites the result.
         if (wb_valid && valid_q[wb_tag]) begin
            done_d[wb_tag] = 1'b1;
            data_d[wb_tag] = wb_data;
         end
         if (w_commit_fire) begin
            valid_d[head_q] = 1'b0;
            done_d[head_q]  = 1'b0;
            head_d          = head_q + TAG_W'(1);
         end
         // Alloc can only target the head slot when the buffer is empty,
         // so it never collides with the commit above.
         if (w_alloc_fire) begin
            valid_d[tail_q]   = 1'b1;
            done_d[tail_q]    = 1'b0;
            uses_rw_d[tail_q] = alloc_uses_rw;
            rw_addr_d[tail_q] = alloc_rw_addr;
            tail_d            = tail_q + TAG_W'(1);
         end
         count_d = count_q + {{TAG_W{1'b0}}, w_alloc_fire}
                           - {{TAG_W{1'b0}}, w_commit_fire};
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_q <= '0;
         done_q  <= '0;
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
      end else begin
         valid_q <= valid_d;
         done_q  <= done_d;
         head_q  <= head_d;
         tail_q  <= tail_d;
         count_q <= count_d;
      end
   end

   always_ff @(posedge clk) begin
      uses_rw_q <= uses_rw_d;
      rw_addr_q <= rw_addr_d;
      data_q    <= data_d;
   end

endmodule
`default_nettype wire
